// File: rtl/nv_nvdla_pdp_rdma_pkg.sv
// Shared widths, field offsets and mask encoding for the PDP RDMA egress response path.
package nv_nvdla_pdp_rdma_pkg;

  localparam int unsigned DATA_W   = 512;
  localparam int unsigned MASK_W   = 2;
  localparam int unsigned PD_W     = DATA_W + MASK_W;
  localparam int unsigned HALF_W   = DATA_W / 2;
  localparam int unsigned MASK_LSB = DATA_W;

  typedef enum logic [MASK_W-1:0] {
    MASK_NONE = 2'd0,
    MASK_LO   = 2'd1,
    MASK_HI   = 2'd2,
    MASK_BOTH = 2'd3
  } mask_e;

endpackage

// File: rtl/nv_nvdla_pdp_rsp_perf_cnt.sv
// Saturating 32-bit event counter.
module nv_nvdla_pdp_rsp_perf_cnt (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/nv_nvdla_pdp_rdma_eg_rsp_unpack.sv
// Splits 514-bit read responses into 256-bit half-beats; zero-mask responses are dropped and flagged.
// Optional perf counters: NV_NVDLA_PDP_RSP_UNPACK_PERF_EN.
module nv_nvdla_pdp_rdma_eg_rsp_unpack
  import nv_nvdla_pdp_rdma_pkg::*;
(
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [PD_W-1:0]   rsp_pd,
  output logic              dp_valid,
  input  logic              dp_ready,
  output logic [HALF_W-1:0] dp_pd,
  output logic              dp_half,
  output logic              dp_last,
  output logic              err_zero_mask
`ifdef NV_NVDLA_PDP_RSP_UNPACK_PERF_EN
  ,
  output logic [31:0]       perf_half_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  mask_e             buf_mask_q, buf_mask_d;
  logic              buf_vld_q,  buf_vld_d;
  logic              ptr_q,      ptr_d;
  logic              err_q,      err_d;

  logic  accept;
  logic  dp_fire;
  mask_e acc_mask;

  assign acc_mask = mask_e'(rsp_pd[MASK_LSB +: MASK_W]);

  assign dp_valid  = buf_vld_q;
  assign dp_half   = ptr_q;
  assign dp_last   = ptr_q || (buf_mask_q == MASK_LO);
  assign dp_pd     = ptr_q ? buf_data_q[DATA_W-1:HALF_W] : buf_data_q[HALF_W-1:0];
  assign dp_fire   = dp_valid && dp_ready;
  assign rsp_ready = !buf_vld_q || (dp_fire && dp_last);
  assign accept    = rsp_valid && rsp_ready;
  assign err_zero_mask = err_q;

  // Accept only happens when empty or on the last drain, so the reload below never races ptr advance.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    buf_vld_d  = buf_vld_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    if (dp_fire) begin
      if (!dp_last) begin
        ptr_d = 1'b1;
      end else begin
        buf_vld_d = 1'b0;
      end
    end
    if (accept) begin
      if (acc_mask != MASK_NONE) begin
        buf_data_d = rsp_pd[DATA_W-1:0];
        buf_mask_d = acc_mask;
        buf_vld_d  = 1'b1;
        ptr_d      = !acc_mask[0];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      buf_mask_q <= MASK_NONE;
      buf_vld_q  <= 1'b0;
      ptr_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      buf_mask_q <= buf_mask_d;
      buf_vld_q  <= buf_vld_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    buf_data_q <= buf_data_d;
  end

`ifdef NV_NVDLA_PDP_RSP_UNPACK_PERF_EN
  nv_nvdla_pdp_rsp_perf_cnt u_half_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .inc             (dp_fire),
    .cnt             (perf_half_cnt)
  );

  nv_nvdla_pdp_rsp_perf_cnt u_stall_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .inc             (dp_valid && !dp_ready),
    .cnt             (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_eg_rsp_unpack.sv
// Directed bench for nv_nvdla_pdp_rdma_eg_rsp_unpack.
module tb_nv_nvdla_pdp_rdma_eg_rsp_unpack;

  logic         clk;
  logic         rstn;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [513:0] rsp_pd;
  logic         dp_valid;
  logic         dp_ready;
  logic [255:0] dp_pd;
  logic         dp_half;
  logic         dp_last;
  logic         err_zero_mask;
`ifdef NV_NVDLA_PDP_RSP_UNPACK_PERF_EN
  logic [31:0]  perf_half_cnt;
  logic [31:0]  perf_stall_cnt;
  logic [31:0]  half_base;
  logic [31:0]  stall_base;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [255:0] lo, hi, a5;

  nv_nvdla_pdp_rdma_eg_rsp_unpack dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_pd          (rsp_pd),
    .dp_valid        (dp_valid),
    .dp_ready        (dp_ready),
    .dp_pd           (dp_pd),
    .dp_half         (dp_half),
    .dp_last         (dp_last),
    .err_zero_mask   (err_zero_mask)
`ifdef NV_NVDLA_PDP_RSP_UNPACK_PERF_EN
    ,
    .perf_half_cnt   (perf_half_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [255:0] pd, input logic half, input logic last,
                      input logic rdy);
    chk({tag, ".valid"}, {255'd0, dp_valid}, 256'd1);
    chk({tag, ".pd"}, dp_pd, pd);
    chk({tag, ".half"}, {255'd0, dp_half}, {255'd0, half});
    chk({tag, ".last"}, {255'd0, dp_last}, {255'd0, last});
    chk({tag, ".rsp_ready"}, {255'd0, rsp_ready}, {255'd0, rdy});
  endtask

  initial begin
    a5        = {32{8'hA5}};
    rstn      = 1'b0;
    rsp_valid = 1'b0;
    rsp_pd    = '0;
    dp_ready  = 1'b1;
    #12;
    chk("rst.dp_valid", {255'd0, dp_valid}, 256'd0);
    chk("rst.dp_half", {255'd0, dp_half}, 256'd0);
    chk("rst.dp_last", {255'd0, dp_last}, 256'd0);
    chk("rst.err", {255'd0, err_zero_mask}, 256'd0);
    chk("rst.rsp_ready", {255'd0, rsp_ready}, 256'd1);
`ifdef NV_NVDLA_PDP_RSP_UNPACK_PERF_EN
    chk("rst.half_cnt", {224'd0, perf_half_cnt}, 256'd0);
    chk("rst.stall_cnt", {224'd0, perf_stall_cnt}, 256'd0);
`endif
    rstn = 1'b1;

    // 1: mask 01
    lo = a5; hi = 256'hDEAD;
    rsp_pd = {2'b01, hi, lo};
    rsp_valid = 1'b1;
    #1;
    chk("t1.rsp_ready_pre", {255'd0, rsp_ready}, 256'd1);
    tick();
    rsp_valid = 1'b0;
    beat("t1", a5, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t1.drained", {255'd0, dp_valid}, 256'd0);

    // 2: mask 11
    lo = 256'h1; hi = 256'h2;
    rsp_pd = {2'b11, hi, lo};
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    beat("t2.b0", 256'h1, 1'b0, 1'b0, 1'b0);
    tick();
    beat("t2.b1", 256'h2, 1'b1, 1'b1, 1'b1);
    tick();
    chk("t2.drained", {255'd0, dp_valid}, 256'd0);

    // 3: four back-to-back mask-10 responses
    for (int i = 0; i < 4; i++) begin
      lo = 256'hBAD; hi = 256'(10 + i);
      rsp_pd = {2'b10, hi, lo};
      rsp_valid = 1'b1;
      tick();
      beat($sformatf("t3.b%0d", i), 256'(10 + i), 1'b1, 1'b1, 1'b1);
    end
    rsp_valid = 1'b0;
    tick();
    chk("t3.drained", {255'd0, dp_valid}, 256'd0);

    // 4: mask 11 with three stall cycles
`ifdef NV_NVDLA_PDP_RSP_UNPACK_PERF_EN
    half_base  = perf_half_cnt;
    stall_base = perf_stall_cnt;
`endif
    dp_ready = 1'b0;
    lo = 256'h3; hi = 256'h4;
    rsp_pd = {2'b11, hi, lo};
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_pd = {2'b01, 256'hF00, 256'hF00};
    beat("t4.b0", 256'h3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat($sformatf("t4.hold%0d", i), 256'h3, 1'b0, 1'b0, 1'b0);
    end
    dp_ready = 1'b1;
    tick();
    beat("t4.b1", 256'h4, 1'b1, 1'b1, 1'b1);
    tick();
    chk("t4.drained", {255'd0, dp_valid}, 256'd0);
`ifdef NV_NVDLA_PDP_RSP_UNPACK_PERF_EN
    chk("t4.stall_cnt", {224'd0, perf_stall_cnt - stall_base}, 256'd3);
    chk("t4.half_cnt", {224'd0, perf_half_cnt - half_base}, 256'd2);
`endif

    // 5: zero mask on an idle buffer
    chk("t5.err_pre", {255'd0, err_zero_mask}, 256'd0);
    rsp_pd = {2'b00, 256'h7, 256'h7};
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("t5.dp_valid", {255'd0, dp_valid}, 256'd0);
    chk("t5.err", {255'd0, err_zero_mask}, 256'd1);
    tick();
    tick();
    chk("t5.err_sticky", {255'd0, err_zero_mask}, 256'd1);
    chk("t5.rsp_ready", {255'd0, rsp_ready}, 256'd1);

    // 5b: zero mask accepted while the buffer drains its last half
    rsp_pd = {2'b01, 256'h0, 256'h55};
    rsp_valid = 1'b1;
    tick();
    rsp_pd = {2'b00, 256'h66, 256'h66};
    beat("t5b.b0", 256'h55, 1'b0, 1'b1, 1'b1);
    tick();
    rsp_valid = 1'b0;
    chk("t5b.empty", {255'd0, dp_valid}, 256'd0);

    // 6: reset between the halves of a mask-11 response
    rsp_pd = {2'b11, 256'h9, 256'h8};
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    beat("t6.b0", 256'h8, 1'b0, 1'b0, 1'b0);
    #1;
    rstn = 1'b0;
    #1;
    chk("t6.async_valid", {255'd0, dp_valid}, 256'd0);
    chk("t6.async_ready", {255'd0, rsp_ready}, 256'd1);
    chk("t6.err_cleared", {255'd0, err_zero_mask}, 256'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6.no_stale%0d", i), {255'd0, dp_valid}, 256'd0);
    end
    chk("t6.rsp_ready", {255'd0, rsp_ready}, 256'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_pdp_rdma_eg_rsp_unpack.md
Name: nv_nvdla_pdp_rdma_eg_rsp_unpack

Overview:
Consumes the 514-bit read-response stream leaving the egress pipe stage.
- Payload layout: pd[511:0] data, pd[513:512] half-mask.
- Splits each response into one or two 256-bit half-beats for the PDP RDMA latency-FIFO write side.
- Zero-mask responses are dropped and flagged.
- Fully valid/ready handshaked, single clock domain.

Parameters:
PD_W, 514, input payload width (DATA_W + MASK_W)
DATA_W, 512, response data width
HALF_W, 256, output half-beat width (DATA_W/2)
MASK_W, 2, mask width; bit0 = half 0 (pd[255:0]), bit1 = half 1 (pd[511:256])

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rstn  input  1  reset, asynchronous, active-low
rsp_valid  input  1  upstream response valid (from pipe stage valid_d1)
rsp_ready  output  1  upstream ready (to pipe stage ready_d1)
rsp_pd  input  PD_W  response payload
dp_valid  output  1  half-beat valid
dp_ready  input  1  downstream ready
dp_pd  output  HALF_W  half-beat data
dp_half  output  1  source half index of dp_pd (0 = low, 1 = high)
dp_last  output  1  last half-beat of the current response
err_zero_mask  output  1  sticky: a response with mask 2'b00 was accepted

Behaviour:
Reset and clock:
- Single clock: nvdla_core_clk.
- Asynchronous active-low reset: nvdla_core_rstn.
- Reset values: dp_valid=0, dp_half=0, dp_last=0, err_zero_mask=0, internal buf_vld=0, rsp_ready=1 (combinational from buf_vld=0).
- dp_pd and data buffer are not reset; dp_pd is don't-care while dp_valid=0.

Storage:
- One-entry buffer: buf_data[511:0], buf_mask[1:0], buf_vld, half pointer ptr.

Handshakes:
- Accept: rsp_valid && rsp_ready.
- rsp_ready = !buf_vld || (dp_valid && dp_ready && dp_last). This is combinational and enables back-to-back acceptance with no bubble.
- On accept with mask != 0: load buffer; buf_vld=1; ptr = 0 if mask[0] else 1.
- On accept with mask == 0: nothing is loaded; buf_vld=0 next cycle (if the buffer was also draining); err_zero_mask<=1.

Outputs:
- dp_valid = buf_vld (registered, one-cycle latency from accept).
- dp_pd = ptr ? buf_data[511:256] : buf_data[255:0].
- dp_half = ptr.
- dp_last = (ptr==1) || (buf_mask==2'b01).

Buffer state machine, each dp_valid && dp_ready:
- If !dp_last: ptr<=1 and buffer is held (mask 2'b11, first half done).
- If dp_last: buf_vld<=0, unless a new accept happens in the same cycle, which reloads the buffer.
- dp_valid && !dp_ready: all outputs held stable (dp_pd, dp_half and dp_last unchanged).

Throughput:
- Mask 01 or 10: 1 response/cycle.
- Mask 11: 1 response/2 cycles.

Boundaries:
- Simultaneous last-drain and accept: buffer replaced, dp_valid stays 1, no bubble.
- Zero-mask accept while the buffer drains: buffer empties, error set.
- Reset mid-transfer: buffer discarded immediately, no partial half emitted after reset release.
- rsp_pd is sampled only on accept.

Optional Feature:
Macro: NV_NVDLA_PDP_RSP_UNPACK_PERF_EN.
- When defined, adds two outputs:
  - perf_half_cnt[31:0]: increments on each dp handshake.
  - perf_stall_cnt[31:0]: increments each cycle with dp_valid && !dp_ready.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package nv_nvdla_pdp_rdma_pkg holds:
  - PD_W, DATA_W, HALF_W, MASK_W.
  - Mask field offsets (MASK_LSB=512).
  - Enum mask_e {MASK_NONE=0, MASK_LO=1, MASK_HI=2, MASK_BOTH=3}.
- One natural sub-module: nv_nvdla_pdp_rsp_perf_cnt, a saturating 32-bit counter instantiated twice under the macro.
- Everything else lives in the top module.

Test Plan:
1. Reset, then rsp_pd mask 01 with data low=256'hA5..A5, dp_ready=1 → cycle+1: dp_valid=1, dp_pd=A5..A5, dp_half=0, dp_last=1; rsp_ready stays 1.
2. Mask 11, low=256'h1, high=256'h2, dp_ready=1 → two beats: (pd=1, half=0, last=0) then (pd=2, half=1, last=1); rsp_ready=0 during the first beat, 1 during the second.
3. Stream of 4 mask-10 responses back-to-back, dp_ready=1 → 4 consecutive beats, half=1, last=1, no bubbles.
4. Mask 11 with dp_ready=0 for 3 cycles → dp_pd/dp_half/dp_last stable, rsp_ready=0; then ready=1 → both halves emitted in order. With PERF_EN: stall_cnt=3, half_cnt=2.
5. Mask 00 accepted → no dp_valid; err_zero_mask=1 next cycle and remains 1 until reset.
6. Assert nvdla_core_rstn=0 between the halves of a mask-11 response → dp_valid=0 immediately; after release no stale half appears and rsp_ready=1.
